toccata_i2s_tx: RTL and testbench

TOCCATA_I2S_TX -- requirements
Module: toccata_i2s_tx

---
 rtl/toccata_pkg.sv | 8 +
 rtl/toccata_i2s_clkgen.sv | 41 ++++
 rtl/toccata_i2s_tx.sv | 83 ++++++++
 tb/tb_toccata_i2s_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/toccata_pkg.sv
// Shared widths and frame-word type for the toccata I2S transmit path.
package toccata_pkg;
  localparam int SAMPLE_W        = 16;
  localparam int SLOTS_PER_FRAME = 32;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

  typedef logic [2*SAMPLE_W-1:0] frame_word_t;
endpackage

// File: rtl/toccata_i2s_clkgen.sv
// BCLK divider and slot counter; o_fall marks the clk in which bclk drops and the slot advances.
module toccata_i2s_clkgen
  import toccata_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_bclk,
  output logic              o_fall,
  output logic [SLOT_W-1:0] o_slot
);

  logic [7:0]        r_div;
  logic              r_bclk;
  logic [SLOT_W-1:0] r_slot;
  logic              w_tick;

  assign w_tick = (r_div == 8'(BCLK_HALF_DIV - 1));
  // Strobe is combinational so the parent updates its registers on the same edge as the slot.
  assign o_fall = w_tick & r_bclk;
  assign o_bclk = r_bclk;
  assign o_slot = r_slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
      r_slot <= '0;
    end else begin
      if (w_tick) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + 8'd1;
      end
      if (o_fall) r_slot <= r_slot + 1'b1;
    end
  end

endmodule

// File: rtl/toccata_i2s_tx.sv
// I2S transmitter: double-buffers one stereo sample and shifts it out MSB first, one frame per 32 slots.
module toccata_i2s_tx
  import toccata_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] ldata,
  input  logic [SAMPLE_W-1:0] rdata,
  input  logic                endata,
  input  logic                mute,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                frame_load,
  output logic                overrun
);

  logic              w_bclk;
  logic              w_fall;
  logic [SLOT_W-1:0] w_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              w_load;
  frame_word_t       w_word;

  logic              r_lrck;
  logic              r_frame_load;
  logic              r_overrun;
  logic              r_pend_vld;
  frame_word_t       r_pend;
  frame_word_t       r_last;
  frame_word_t       r_shift;

  toccata_i2s_clkgen #(.BCLK_HALF_DIV(BCLK_HALF_DIV)) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .o_bclk (w_bclk),
    .o_fall (w_fall),
    .o_slot (w_slot)
  );

  assign w_slot_nxt = w_slot + 1'b1;
  assign w_load     = w_fall & (w_slot == '0);
  // With nothing new pending, the last sample is repeated rather than dropping to silence.
  assign w_word     = r_pend_vld ? r_pend : r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrck       <= 1'b0;
      r_frame_load <= 1'b0;
      r_overrun    <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend       <= '0;
      r_last       <= '0;
      r_shift      <= '0;
    end else begin
      r_frame_load <= w_load;
      r_overrun    <= endata & r_pend_vld & ~w_load;
      if (w_fall) r_lrck <= w_slot_nxt[SLOT_W-1];
      // r_last tracks the real sample even while muted so unmuting resumes it.
      if (w_load) begin
        r_shift <= mute ? '0 : w_word;
        r_last  <= w_word;
      end else if (w_fall) begin
        r_shift <= {r_shift[$bits(frame_word_t)-2:0], 1'b0};
      end
      if (endata) begin
        r_pend     <= {ldata, rdata};
        r_pend_vld <= 1'b1;
      end else if (w_load) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign i2s_bclk   = w_bclk;
  assign i2s_lrck   = r_lrck;
  assign i2s_sdata  = r_shift[$bits(frame_word_t)-1];
  assign frame_load = r_frame_load;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_toccata_i2s_tx.sv
// Scoreboard bench for toccata_i2s_tx: stimulus queues expected frame words, a monitor reassembles frames.
module tb_toccata_i2s_tx;
  localparam int HD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ldata = '0;
  logic [15:0] rdata = '0;
  logic        endata = 1'b0;
  logic        mute = 1'b0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, frame_load, overrun;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ovr_cnt = 0;
  logic [31:0] exp_q[$];

  toccata_i2s_tx #(.BCLK_HALF_DIV(HD)) dut (
    .clk        (clk),
    .rst        (rst),
    .ldata      (ldata),
    .rdata      (rdata),
    .endata     (endata),
    .mute       (mute),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .frame_load (frame_load),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: frame words assembled from sdata at each BCLK rise after a frame_load.
  initial begin
    logic        prev_bclk, prev_lrck, coll;
    logic [31:0] sh;
    int          bitn, t_bclk, t_lrck, t_load;
    prev_bclk = 0; prev_lrck = 0; coll = 0; sh = '0; bitn = 0;
    t_bclk = -1; t_lrck = -1; t_load = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (coll && exp_q.size() > 0) void'(exp_q.pop_front());
        coll = 0; prev_bclk = 0; prev_lrck = 0;
        t_bclk = -1; t_lrck = -1; t_load = -1;
      end else begin
        if (overrun) ovr_cnt++;
        if (frame_load) begin
          if (t_load >= 0) check("load_period", 32'(cyc - t_load), 32'd256);
          t_load = cyc; coll = 1; bitn = 0;
        end
        if (i2s_bclk && !prev_bclk) begin
          if (t_bclk >= 0) check("bclk_period", 32'(cyc - t_bclk), 32'd8);
          t_bclk = cyc;
          if (coll) begin
            check("lrck_slot", {31'b0, i2s_lrck}, {31'b0, (bitn >= 15 && bitn <= 30)});
            sh = {sh[30:0], i2s_sdata};
            bitn++;
            if (bitn == 32) begin
              coll = 0;
              if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL frame_word: got %h with no expected frame queued", sh);
              end else begin
                check("frame_word", sh, exp_q.pop_front());
              end
            end
          end
        end
        if (i2s_lrck && !prev_lrck) begin
          if (t_lrck >= 0) check("lrck_period", 32'(cyc - t_lrck), 32'd256);
          t_lrck = cyc;
        end
        prev_bclk = i2s_bclk;
        prev_lrck = i2s_lrck;
      end
    end
  end

  task automatic pulse(input logic [15:0] l, input logic [15:0] r);
    ldata = l; rdata = r; endata = 1'b1;
    @(negedge clk);
    endata = 1'b0;
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_load && n < 400);
    n_chk++;
    if (!frame_load) begin
      n_fail++;
      $display("FAIL %s: got no frame_load within %0d clks, expected one", name, n);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bclk"},  {31'b0, i2s_bclk},   32'd0);
    check({tag, "_lrck"},  {31'b0, i2s_lrck},   32'd0);
    check({tag, "_sdata"}, {31'b0, i2s_sdata},  32'd0);
    check({tag, "_load"},  {31'b0, frame_load}, 32'd0);
    check({tag, "_ovr"},   {31'b0, overrun},    32'd0);
  endtask

  // Releases reset and times the first BCLK rise and the first frame load.
  task automatic release_chk();
    int n, t_rise, t_ld;
    n = 0; t_rise = 0; t_ld = 0;
    rst = 1'b0;
    while (t_ld == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (i2s_bclk && t_rise == 0) t_rise = n;
      if (frame_load) t_ld = n;
    end
    check("first_rise", 32'(t_rise), 32'(HD));
    check("first_load", 32'(t_ld), 32'(2 * HD));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_zero("rst");
    exp_q.push_back(32'h0000_0000);
    release_chk();

    pulse(16'hA5C3, 16'h0F01);
    exp_q.push_back(32'hA5C3_0F01);
    wait_load("f2");

    pulse(16'h1234, 16'h8001);
    repeat (4) exp_q.push_back(32'h1234_8001);
    repeat (4) wait_load("hold");

    pulse(16'h1111, 16'h1111);
    repeat (5) @(negedge clk);
    pulse(16'h2222, 16'h2222);
    exp_q.push_back(32'h2222_2222);
    wait_load("f7");
    check("overrun_cnt", 32'(ovr_cnt), 32'd1);

    mute = 1'b1;
    pulse(16'h7FFF, 16'h7FFF);
    exp_q.push_back(32'h0000_0000);
    wait_load("f8");
    mute = 1'b0;
    exp_q.push_back(32'h7FFF_7FFF);
    wait_load("f9");

    // New sample lands exactly on the load edge: old pending goes out, new stays pending.
    repeat (10) @(negedge clk);
    pulse(16'h0001, 16'h0002);
    exp_q.push_back(32'h0001_0002);
    repeat (244) @(negedge clk);
    pulse(16'h0003, 16'h0004);
    check("coincide_load", {31'b0, frame_load}, 32'd1);
    exp_q.push_back(32'h0003_0004);
    wait_load("f11");
    check("overrun_cnt2", 32'(ovr_cnt), 32'd1);
    exp_q.push_back(32'h0003_0004);
    wait_load("f12");

    repeat (66) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h0000_0000);
    release_chk();
    pulse(16'hBEEF, 16'hCAFE);
    exp_q.push_back(32'hBEEF_CAFE);
    wait_load("f14");

    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
